param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 70 +++++++
 tb/tb_param_sync_fifo.sv | 129 ++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with registered read data, level flags and overflow/underflow pulses
module param_sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       re,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             rd_ok, wr_ok;
    assign rd_ok = re && (count_q != '0);
    assign wr_ok = we && ((count_q != CW'(DEPTH)) || rd_ok);
    always_comb begin
        wptr_d  = wr_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = rd_ok ? rptr_q + AW'(1) : rptr_q;
        count_d = (wr_ok && !rd_ok) ? count_q + CW'(1) :
                  (rd_ok && !wr_ok) ? count_q - CW'(1) : count_q;
        dout_d  = rd_ok ? mem[rptr_q] : dout_q;
        ovf_d   = we && !wr_ok;
        udf_d   = re && !rd_ok;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end
    // storage is deliberately unreset; rst only blocks writes while asserted
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wptr_q] <= data_in;
    end
    assign data_out     = dout_q;
    assign count        = count_q;
    assign full         = count_q == CW'(DEPTH);
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= CW'(AF_LEVEL);
    assign almost_empty = count_q <= CW'(AE_LEVEL);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed self-checking bench for param_sync_fifo at WIDTH=8, DEPTH=16, AF=14, AE=2
module tb_param_sync_fifo;
    logic       clk, rst, we, re;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;
    int         passed = 0;
    int         total = 0;
    param_sync_fifo dut (
        .clk(clk), .rst(rst), .we(we), .data_in(data_in), .re(re),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_ae"}, 32'(almost_empty), 1);
        check({tag, "_af"}, 32'(almost_full), 0);
        check({tag, "_dout"}, 32'(data_out), 0);
        check({tag, "_ovf"}, 32'(overflow), 0);
        check({tag, "_udf"}, 32'(underflow), 0);
    endtask
    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; data_in = '0;
        tick();
        tick();
        check_reset("rst0");
        rst = 1'b0;
        // fill 0x01..0x10, watching the level flags at every count
        for (int i = 1; i <= 16; i++) begin
            we = 1'b1; data_in = 8'(i);
            tick();
            check("fill_count", 32'(count), 32'(i));
            check("fill_ae", 32'(almost_empty), 32'(i <= 2));
            check("fill_af", 32'(almost_full), 32'(i >= 14));
            check("fill_full", 32'(full), 32'(i == 16));
        end
        data_in = 8'hAA;
        tick();
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_count", 32'(count), 16);
        we = 1'b0;
        tick();
        check("ovf_clear", 32'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            re = 1'b1;
            tick();
            check("drain_dout", 32'(data_out), 32'(i + 1));
            check("drain_count", 32'(count), 32'(15 - i));
            check("drain_empty", 32'(empty), 32'(i == 15));
        end
        we = 1'b1; data_in = 8'h55;
        tick();
        check("udf_pulse", 32'(underflow), 1);
        check("udf_count", 32'(count), 1);
        we = 1'b0; re = 1'b0;
        tick();
        check("udf_clear", 32'(underflow), 0);
        check("udf_hold", 32'(data_out), 32'h10);
        re = 1'b1;
        tick();
        check("udf_read", 32'(data_out), 32'h55);
        check("udf_empty", 32'(empty), 1);
        re = 1'b0;
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; data_in = 8'(8'h20 + i);
            tick();
        end
        check("wrap_full", 32'(full), 1);
        // full with simultaneous read/write: count pinned, order kept across pointer wrap
        for (int k = 0; k < 20; k++) begin
            we = 1'b1; re = 1'b1; data_in = 8'(8'h30 + k);
            tick();
            check("wrap_dout", 32'(data_out), 32'(8'h20 + k));
            check("wrap_count", 32'(count), 16);
            check("wrap_ovf", 32'(overflow), 0);
        end
        we = 1'b0;
        for (int j = 0; j < 16; j++) begin
            tick();
            check("wrap_drain", 32'(data_out), 32'(8'h34 + j));
        end
        re = 1'b0;
        tick();
        check("wrap_empty", 32'(empty), 1);
        for (int i = 0; i < 9; i++) begin
            we = 1'b1; data_in = 8'(8'h60 + i);
            tick();
        end
        we = 1'b0;
        tick();
        check("pre_rst_count", 32'(count), 9);
        #2;
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        we = 1'b1; re = 1'b1; data_in = 8'hEE;
        tick();
        check("rst_ignore_count", 32'(count), 0);
        check("rst_ignore_dout", 32'(data_out), 0);
        re = 1'b0; we = 1'b0;
        #2;
        rst = 1'b0;
        we = 1'b1; data_in = 8'h77;
        tick();
        check("post_rst_count", 32'(count), 1);
        we = 1'b0; re = 1'b1;
        tick();
        check("post_rst_dout", 32'(data_out), 32'h77);
        check("post_rst_empty", 32'(empty), 1);
        re = 1'b0;
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
